// File: rtl/cdb_arbiter_pkg.sv
// Common data bus payload types shared by the arbiter, its result FIFOs and consumers.
`include "macros.sv"

package cdb_arbiter_pkg;

  localparam int NUM_CDB     = `NUM_CDB_ENTRIES;
  localparam int ROB_ENTRIES = `RO_BUFFER_ENTRIES;
  localparam int TW          = $clog2(ROB_ENTRIES);

  // A tag of zero marks an empty slot; ROB entry 0 is never allocated.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   value;
    logic [31:0]   target_pc;
  } cdb_entry_t;

  typedef cdb_entry_t [NUM_CDB-1:0] cdb_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-functional-unit result buffer; flush empties it and takes priority over push/pop.
module cdb_result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t data,
  output cdb_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  cdb_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // NOTE: storage is deliberately left out of reset; count gates every read, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= data;
  end

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/macros.sv
// Global machine-configuration macros shared by the out-of-order core.
`ifndef CDB_MACROS_SV
`define CDB_MACROS_SV
`define NUM_CDB_ENTRIES 2
`define RO_BUFFER_ENTRIES 8
`endif

// File: rtl/cdb_arbiter.sv
// CDB producer: buffers FU results and broadcasts up to NUM_CDB of them per cycle, round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [NUM_FU-1:0][TW-1:0] fu_tag,
  input  logic [NUM_FU-1:0][31:0]  fu_value,
  input  logic [NUM_FU-1:0][31:0]  fu_target_pc,
  output cdb_t                     cdb
);

  localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] push, pop, empty, full;
  cdb_entry_t        in_data [NUM_FU];
  cdb_entry_t        head    [NUM_FU];

  cdb_t          cdb_q, cdb_d;
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;

  assign fu_ready = ~full;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign in_data[g] = '{tag: fu_tag[g], value: fu_value[g], target_pc: fu_target_pc[g]};
    // Tag 0 is reserved: the handshake completes but nothing is buffered.
    assign push[g] = fu_valid[g] && fu_ready[g] && (fu_tag[g] != '0) && !flush;

    cdb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .data  (in_data[g]),
      .head  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  always_comb begin
    int idx;
    int n_grant;
    pop      = '0;
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    n_grant  = 0;
    idx      = 0;
    for (int j = 0; j < NUM_FU; j++) begin
      idx = (int'(rr_ptr_q) + j) % NUM_FU;
      if (!empty[idx] && n_grant < NUM_CDB) begin
        pop[idx]       = 1'b1;
        cdb_d[n_grant] = head[idx];
        rr_ptr_d       = RW'((idx + 1) % NUM_FU);
        n_grant        = n_grant + 1;
      end
    end
    if (flush) begin
      pop      = '0;
      cdb_d    = '0;
      rr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign cdb = cdb_q;

endmodule
